// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg -- shared definitions for the universal shift register.
//   Opcodes for the 3-bit op command, FSM state encoding, per-bit mux
//   select encoding, and a helper that tells whether an opcode performs
//   single-bit steps.
//   Optional feature macro: SHIFT_ROTATE_EN (enables ROR/ROL; otherwise
//   those opcodes behave as NOP).
package shift_reg_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Source selected by each bit of the register on a clock edge.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_RIGHT = 2'b01,  // take the bit above (shift towards lsb)
    SEL_LEFT  = 2'b10,  // take the bit below (shift towards msb)
    SEL_LOAD  = 2'b11
  } bit_sel_t;

  // True for opcodes that run through the step counter.
  function automatic logic is_step_op(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SHR, OP_SHL, OP_SAR: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_bit_mux.sv
// shift_bit_mux -- next-value selector for one bit of the shift register.
//   sel       : hold / right neighbour / left neighbour / load
//   hold_bit  : current value of this bit
//   right_bit : value of the bit above (or the msb fill input at the top)
//   left_bit  : value of the bit below (or the lsb fill input at the bottom)
//   load_bit  : parallel load value for this bit
//   q_next    : value this bit takes on the next edge
module shift_bit_mux
  import shift_reg_pkg::*;
(
  input  bit_sel_t sel,
  input  logic     hold_bit,
  input  logic     right_bit,
  input  logic     left_bit,
  input  logic     load_bit,
  output logic     q_next
);

  always_comb begin
    q_next = hold_bit;
    case (sel)
      SEL_HOLD:  q_next = hold_bit;
      SEL_RIGHT: q_next = right_bit;
      SEL_LEFT:  q_next = left_bit;
      SEL_LOAD:  q_next = load_bit;
      default:   q_next = hold_bit;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- WIDTH-bit universal shift register with multi-step
// shift/rotate commands, a busy/done handshake and an lsb override.
//   clk, reset      : clock and synchronous active-high reset
//   start, op       : command strobe (sampled in IDLE) and opcode
//   amount          : number of steps for shift/rotate (clamped to WIDTH)
//   din             : serial fill bit, also the set_lsb value
//   set_lsb         : in IDLE without start, q[0] <= din
//   load_data       : parallel load value
//   q, sout         : register contents and last shifted-out bit
//   busy, done      : in SHIFT state / one-cycle completion pulse
// Optional feature macro: SHIFT_ROTATE_EN -- when undefined, ROR/ROL decode
// as NOP and the rotate wrap paths are absent.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             din,
  input  logic             set_lsb,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             sout_reg, sout_next;
  logic             done_reg, done_next;

  logic [CNT_W-1:0] amount_clamped;
  logic [2:0]       step_op;
  logic             step_en;
  logic             load_en;
  logic             lsb_en;
  logic             right_dir;
  logic             msb_in;
  logic             lsb_in;
  bit_sel_t         sel_all;
  bit_sel_t         bit_sel [WIDTH];

  assign amount_clamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      q_reg     <= '0;
      sout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      q_reg     <= q_next;
      sout_reg  <= sout_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: counter and latched opcode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next = op;
          if (is_step_op(op) && (amount_clamped != '0)) begin
            // First step happens on the start edge itself.
            cnt_next = amount_clamped - CNT_W'(1);
            if (amount_clamped > CNT_W'(1)) begin
              state_next = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    step_en   = 1'b0;
    step_op   = op_reg;
    load_en   = 1'b0;
    lsb_en    = 1'b0;
    done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          step_op = op;
          if (is_step_op(op)) begin
            if (amount_clamped == '0) begin
              done_next = 1'b1;
            end else begin
              step_en   = 1'b1;
              done_next = (amount_clamped == CNT_W'(1));
            end
          end else begin
            // LOAD, NOP, reserved and (when disabled) rotates.
            load_en   = (op == OP_LOAD);
            done_next = 1'b1;
          end
        end else if (set_lsb) begin
          lsb_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        step_en   = 1'b1;
        done_next = (cnt_reg == CNT_W'(1));
      end
      default: ;
    endcase
  end

  always_comb begin
    right_dir = (step_op == OP_SHR) || (step_op == OP_SAR) || (step_op == OP_ROR);

    msb_in = din;
    if (step_op == OP_SAR) begin
      msb_in = q_reg[WIDTH-1];
    end
`ifdef SHIFT_ROTATE_EN
    if (step_op == OP_ROR) begin
      msb_in = q_reg[0];
    end
`endif

    // Gated with step_en so a latched ROL cannot hijack the set_lsb path.
    lsb_in = din;
`ifdef SHIFT_ROTATE_EN
    if (step_en && (step_op == OP_ROL)) begin
      lsb_in = q_reg[WIDTH-1];
    end
`endif

    if (load_en) begin
      sel_all = SEL_LOAD;
    end else if (step_en) begin
      sel_all = right_dir ? SEL_RIGHT : SEL_LEFT;
    end else begin
      sel_all = SEL_HOLD;
    end

    sout_next = sout_reg;
    if (step_en) begin
      sout_next = right_dir ? q_reg[0] : q_reg[WIDTH-1];
    end
  end

  // One mux per bit; edge bits take the fill inputs instead of a neighbour.
  // set_lsb reuses the left-shift path of bit 0 with lsb_in = din.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic right_src;
      logic left_src;

      if (gi == WIDTH - 1) begin : g_top
        assign right_src = msb_in;
      end else begin : g_mid_r
        assign right_src = q_reg[gi+1];
      end

      if (gi == 0) begin : g_bot
        assign left_src    = lsb_in;
        assign bit_sel[gi] = lsb_en ? SEL_LEFT : sel_all;
      end else begin : g_mid_l
        assign left_src    = q_reg[gi-1];
        assign bit_sel[gi] = sel_all;
      end

      shift_bit_mux u_mux (
        .sel       (bit_sel[gi]),
        .hold_bit  (q_reg[gi]),
        .right_bit (right_src),
        .left_bit  (left_src),
        .load_bit  (load_data[gi]),
        .q_next    (q_next[gi])
      );
    end
  endgenerate

  assign q    = q_reg;
  assign sout = sout_reg;
  assign busy = (state_reg == ST_SHIFT);
  assign done = done_reg;

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register for the datapath's multiply/divide sequencing. It generalises the fixed 8-bit hold/shift/load register to WIDTH bits and adds arithmetic-right and rotate modes. It also adds multi-step shifts driven by an internal step counter with a busy/done handshake. A single-bit LSB override (Q[0] <= din) is kept so the divider can insert quotient bits.

## Interface
- WIDTH, 8, register width (>= 2)
- CNT_W, $clog2(WIDTH+1), localparam, width of amount and step counter

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- op  in  3  command: 000 NOP, 001 SHR, 010 SHL, 011 LOAD, 100 SAR, 101 ROR, 110 ROL, 111 reserved (= NOP)
- amount  in  CNT_W  number of single-bit steps for shift/rotate ops
- din  in  1  serial input, sampled on every shift step and by set_lsb
- set_lsb  in  1  in IDLE without start: Q[0] <= din, other bits hold
- load_data  in  WIDTH  parallel load value
- q  out  WIDTH  register contents
- sout  out  1  bit shifted out on the most recent step
- busy  out  1  high while in SHIFT state
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT. Step counter cnt is CNT_W bits.
- Per-step semantics:
  - SHR: q <= {din, q[W-1:1]}, sout <= q[0].
  - SHL: q <= {q[W-2:0], din}, sout <= q[W-1].
  - SAR: msb is replicated, sout <= q[0].
  - ROR/ROL: the bit that leaves re-enters at the opposite end, and sout also gets that bit. din is ignored.
- Starting a shift/rotate, IDLE & start:
  - amount > WIDTH is clamped to WIDTH.
  - Let k be the clamped amount. k = 0: no step, done next cycle.
  - k >= 1: the first step is performed on the start edge and cnt <= k-1. If k-1 = 0, done pulses next cycle and the block stays IDLE. Otherwise the block goes to SHIFT.
- SHIFT: one step per cycle with cnt decremented. The step taken with cnt = 1 is the last; the block returns to IDLE and done <= 1.
- The op code is latched at start; changes to op during SHIFT have no effect.
- LOAD with start: q <= load_data, sout unchanged, done next cycle, busy never asserted.
- NOP/reserved with start: q unchanged, done next cycle.
- start while busy: ignored, no queuing.
- set_lsb:
  - Acts only in IDLE with start low.
  - Ignored when start is high (start has priority) and ignored during SHIFT.
  - Produces no done pulse.
- reset: q = 0, sout = 0, busy = 0, done = 0, cnt = 0, state IDLE. Reset mid-shift aborts the operation; no done pulse follows.

## Timing
- Start edge = edge 0. With k steps:
  - q holds its final value after edge k-1.
  - done is high in the cycle following edge k-1.
  - busy is high for k-1 cycles, from after edge 0 until the edge that raises done. busy and done are never high together.
- LOAD, NOP and k = 0 complete in one cycle: done is high in the cycle after edge 0.
- A new start is accepted in the same cycle done is high, because the state is already IDLE.
- All outputs are registered.

## Configuration
- SHIFT_ROTATE_EN defined: ROR/ROL operate as specified.
- SHIFT_ROTATE_EN undefined:
  - Opcodes 101/110 decode as NOP (q unchanged, done next cycle, no busy).
  - The rotate wrap paths are not synthesised.

## Structure
- Package shift_reg_pkg holds:
  - opcode localparams (OP_NOP, OP_SHR, OP_SHL, OP_LOAD, OP_SAR, OP_ROR, OP_ROL);
  - state encoding (ST_IDLE, ST_SHIFT).
- Sub-module shift_bit_mux, instantiated once per bit in a generate loop:
  - selects hold / right neighbour / left neighbour / load bit;
  - edge bits get din, msb, or wrap input from the parent.
- The FSM, counter, clamp, sout and set_lsb logic live in univ_shift_reg.

## Test plan
All scenarios use WIDTH = 8.
- Reset, then start LOAD load_data = 0xA5 -> q = 0xA5 and done high one cycle after the start edge; busy stays 0.
- q = 0xA5, start SHR amount = 3, din = 1 -> q goes D2, E9, F4; sout goes 1, 0, 1; busy high 2 cycles; done in cycle 3.
- q = 0x81, start SAR amount = 2 -> q = 0xE0, sout = 0. Then start ROL amount = 1 -> q = 0xC1 with SHIFT_ROTATE_EN; without the macro q stays 0xE0 and done still pulses.
- q = 0xFF, start SHL amount = 15, din = 0 -> clamped to 8 steps; q = 0x00 and done in cycle 8. A start issued at cycle 3 with op = LOAD is ignored.
- start SHL amount = 0 -> q unchanged, done next cycle. Idle set_lsb = 1, din = 1 on q = 0x10 -> q = 0x11, no done.
- q = 0x01, start SHL amount = 5, din = 0; assert reset at cycle 2 -> q = 0, busy = 0, and done never pulses.
